// File: rtl/arb_pkg.sv
// arb_pkg: shared state type and round-robin pick helper for the stream arbiters
package arb_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;
  // Scan n requesters starting at ptr with modular wrap; the first hit wins
  function automatic pick_t rr_pick(input logic [15:0] req, input logic [3:0] ptr, input int n);
    pick_t p;
    int j;
    p = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < n && !p.found) begin
        j = int'(ptr) + k;
        if (j >= n) j -= n;
        if (req[j[3:0]]) begin
          p.found = 1'b1;
          p.idx = j[3:0];
        end
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/rr_select.sv
// rr_select: combinational round-robin priority picker over NUM_SLV requesters
module rr_select import arb_pkg::*; #(
  parameter int NUM_SLV = 4,
  parameter int SRC_W = $clog2(NUM_SLV)
) (
  input  logic [NUM_SLV-1:0] req_i,
  input  logic [SRC_W-1:0]   ptr_i,
  output logic [SRC_W-1:0]   grant_o,
  output logic               found_o
);
  pick_t p;
  always_comb begin
    p = rr_pick(16'(req_i), 4'(ptr_i), NUM_SLV);
    grant_o = SRC_W'(p.idx);
    found_o = p.found;
  end
endmodule

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter: round-robin, burst-locked merge of NUM_SLV slave streams into one FIFO stream
module rr_burst_arbiter import arb_pkg::*; #(
  parameter int NUM_SLV = 4,
  parameter int DW = 32,
  parameter int MODE_W = 2,
  parameter int MAX_BURST = 16,
  parameter int SRC_W = $clog2(NUM_SLV)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SLV*MODE_W-1:0] slv_mode,
  input  logic [NUM_SLV-1:0]        slv_data_valid,
  input  logic [NUM_SLV-1:0]        slv_proc_valid,
  input  logic [NUM_SLV*DW-1:0]     slv_data,
  output logic [NUM_SLV-1:0]        slv_ready,
  output logic [MODE_W-1:0]         slvx_mode,
  output logic                      slvx_data_valid,
  output logic                      slvx_proc_val,
  output logic [DW-1:0]             slvx_data,
  output logic [SRC_W-1:0]          data_source,
  input  logic                      fifo_full,
  input  logic                      fifo_empty,
  input  logic                      proc_cmplt,
  output logic                      mstr_cmplt
);
  localparam int CW = $clog2(MAX_BURST + 1);
  state_t            state_q, state_d;
  logic [SRC_W-1:0]  grant_q, grant_d, ptr_q, ptr_d, pick, nxt;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mc_q, vld_q, vld_d, pv_q, pv_d;
  logic [MODE_W-1:0] mode_q, mode_d, gmode;
  logic [DW-1:0]     data_q, data_d, gdata;
  logic [NUM_SLV-1:0] req;
  logic              found, open, acc, last;
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_SLV; i++) req[i] = |slv_mode[i*MODE_W +: MODE_W];
  end
  rr_select #(.NUM_SLV(NUM_SLV), .SRC_W(SRC_W)) u_sel (
    .req_i(req), .ptr_i(ptr_q), .grant_o(pick), .found_o(found)
  );
  assign gmode = slv_mode[grant_q*MODE_W +: MODE_W];
  assign gdata = slv_data[grant_q*DW +: DW];
  assign open  = state_q == BURST && !fifo_full && !mc_q;
  assign acc   = open && slv_data_valid[grant_q];
  assign last  = slv_proc_valid[grant_q] || cnt_q + 1'b1 == CW'(MAX_BURST);
  assign nxt   = grant_q == SRC_W'(NUM_SLV - 1) ? '0 : grant_q + 1'b1;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    vld_d = 1'b0;
    data_d = '0;
    mode_d = mode_q;
    pv_d = pv_q;
    if (mc_q) begin
      state_d = IDLE;
      cnt_d = '0;
      mode_d = '0;
      pv_d = 1'b0;
      ptr_d = state_q == BURST ? nxt : ptr_q;
    end else if (state_q == IDLE) begin
      if (found && !fifo_full) begin
        state_d = BURST;
        grant_d = pick;
        cnt_d = '0;
      end
    end else if (acc) begin
      vld_d = 1'b1;
      data_d = gdata;
      mode_d = gmode;
      pv_d = slv_proc_valid[grant_q];
      cnt_d = cnt_q + 1'b1;
      state_d = last ? IDLE : BURST;
      ptr_d = last ? nxt : ptr_q;
    end else if (!req[grant_q]) begin
      state_d = IDLE;
      ptr_d = nxt;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      mc_q <= 1'b0;
      vld_q <= 1'b0;
      pv_q <= 1'b0;
      mode_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      mc_q <= proc_cmplt & ~fifo_empty;
      vld_q <= vld_d;
      pv_q <= pv_d;
      mode_q <= mode_d;
      data_q <= data_d;
    end
  end
  // Completion flush masks the whole output side for the cycle it is raised
  assign slv_ready       = open ? NUM_SLV'(1) << grant_q : '0;
  assign slvx_data_valid = vld_q & ~mc_q;
  assign slvx_proc_val   = pv_q & ~mc_q;
  assign slvx_mode       = mc_q ? '0 : mode_q;
  assign slvx_data       = mc_q ? '0 : data_q;
  assign data_source     = mc_q ? '0 : grant_q;
  assign mstr_cmplt      = mc_q;
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// tb_rr_burst_arbiter: directed cycle vectors plus a mid-stream reset sequence
module tb_rr_burst_arbiter;
  typedef struct packed {
    logic [3:0]  rdy;
    logic        v;
    logic        pv;
    logic [1:0]  mode;
    logic [31:0] data;
    logic [1:0]  src;
    logic        mc;
  } out_t;
  typedef struct packed {
    logic [7:0] mode;
    logic [3:0] dv;
    logic [3:0] pv;
    logic       full;
    logic       empty;
    logic       pc;
    out_t       e;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  slv_mode = '0;
  logic [3:0]  slv_data_valid = '0;
  logic [3:0]  slv_proc_valid = '0;
  logic [127:0] slv_data;
  logic [3:0]  slv_ready;
  logic [1:0]  slvx_mode;
  logic        slvx_data_valid;
  logic        slvx_proc_val;
  logic [31:0] slvx_data;
  logic [1:0]  data_source;
  logic        fifo_full = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        proc_cmplt = 1'b0;
  logic        mstr_cmplt;
  logic [7:0]  cnt [4];
  int tests = 0;
  int fails = 0;
  vec_t v [42];
  rr_burst_arbiter #(.NUM_SLV(4), .DW(32), .MODE_W(2), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .slv_mode(slv_mode), .slv_data_valid(slv_data_valid),
    .slv_proc_valid(slv_proc_valid), .slv_data(slv_data), .slv_ready(slv_ready),
    .slvx_mode(slvx_mode), .slvx_data_valid(slvx_data_valid), .slvx_proc_val(slvx_proc_val),
    .slvx_data(slvx_data), .data_source(data_source), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .proc_cmplt(proc_cmplt), .mstr_cmplt(mstr_cmplt)
  );
  always #5 clk = ~clk;
  // Each slave emits {index, beat number} and advances only on a handshake
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) cnt[i] <= 8'd0;
      else if (slv_ready[i] && slv_data_valid[i]) cnt[i] <= cnt[i] + 8'd1;
    end
  end
  always_comb begin
    slv_data = '0;
    for (int i = 0; i < 4; i++) slv_data[i*32 +: 32] = {16'h0, 8'(i), cnt[i]};
  end
  function automatic vec_t mk(input int m, dv, pv, fu, em, pc, r, vl, xp, xm, xd, s, mc);
    vec_t t;
    t.mode = 8'(m);
    t.dv = 4'(dv);
    t.pv = 4'(pv);
    t.full = 1'(fu);
    t.empty = 1'(em);
    t.pc = 1'(pc);
    t.e = '{rdy: 4'(r), v: 1'(vl), pv: 1'(xp), mode: 2'(xm), data: 32'(xd), src: 2'(s), mc: 1'(mc)};
    return t;
  endfunction
  task automatic check(input string nm, input out_t e);
    out_t g;
    g = {slv_ready, slvx_data_valid, slvx_proc_val, slvx_mode, slvx_data, data_source, mstr_cmplt};
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s got rdy=%h v=%b pv=%b mode=%h data=%h src=%0d mc=%b exp rdy=%h v=%b pv=%b mode=%h data=%h src=%0d mc=%b",
               nm, g.rdy, g.v, g.pv, g.mode, g.data, g.src, g.mc, e.rdy, e.v, e.pv, e.mode, e.data, e.src, e.mc);
    end
  endtask
  initial begin
    v[0]  = mk('h55, 'hF, 0, 0, 1, 0,  0, 0, 0, 0, 'h0000, 0, 0);
    v[1]  = mk('h55, 'hF, 0, 0, 1, 0,  1, 0, 0, 0, 'h0000, 0, 0);
    v[2]  = mk('h55, 'hF, 0, 0, 1, 0,  1, 1, 0, 1, 'h0000, 0, 0);
    v[3]  = mk('h55, 'hF, 1, 0, 1, 0,  1, 1, 0, 1, 'h0001, 0, 0);
    v[4]  = mk('h55, 'hF, 0, 0, 1, 0,  0, 1, 1, 1, 'h0002, 0, 0);
    v[5]  = mk('h55, 'hF, 0, 0, 1, 0,  2, 0, 1, 1, 'h0000, 1, 0);
    v[6]  = mk('h55, 'hF, 0, 0, 1, 0,  2, 1, 0, 1, 'h0100, 1, 0);
    v[7]  = mk('h55, 'hF, 2, 0, 1, 0,  2, 1, 0, 1, 'h0101, 1, 0);
    v[8]  = mk('h55, 'hF, 0, 0, 1, 0,  0, 1, 1, 1, 'h0102, 1, 0);
    v[9]  = mk('h55, 'hF, 0, 0, 1, 0,  4, 0, 1, 1, 'h0000, 2, 0);
    v[10] = mk('h55, 'hF, 0, 0, 1, 0,  4, 1, 0, 1, 'h0200, 2, 0);
    v[11] = mk('h55, 'hF, 4, 0, 1, 0,  4, 1, 0, 1, 'h0201, 2, 0);
    v[12] = mk('h55, 'hF, 0, 0, 1, 0,  0, 1, 1, 1, 'h0202, 2, 0);
    v[13] = mk('h55, 'hF, 0, 0, 1, 0,  8, 0, 1, 1, 'h0000, 3, 0);
    v[14] = mk('h55, 'hF, 0, 0, 1, 0,  8, 1, 0, 1, 'h0300, 3, 0);
    v[15] = mk('h55, 'hF, 8, 0, 1, 0,  8, 1, 0, 1, 'h0301, 3, 0);
    v[16] = mk('h55, 'hF, 0, 0, 1, 0,  0, 1, 1, 1, 'h0302, 3, 0);
    v[17] = mk('h55, 'hF, 0, 0, 1, 0,  1, 0, 1, 1, 'h0000, 0, 0);
    v[18] = mk('h55, 'hF, 0, 1, 1, 0,  0, 1, 0, 1, 'h0003, 0, 0);
    for (int k = 19; k < 23; k++) v[k] = mk('h55, 'hF, 0, 1, 1, 0,  0, 0, 0, 1, 'h0000, 0, 0);
    v[23] = mk('h55, 'hF, 0, 0, 1, 0,  1, 0, 0, 1, 'h0000, 0, 0);
    v[24] = mk('h55, 'hF, 0, 0, 1, 0,  1, 1, 0, 1, 'h0004, 0, 0);
    v[25] = mk('h55, 'hF, 0, 0, 1, 0,  1, 1, 0, 1, 'h0005, 0, 0);
    v[26] = mk('h50, 'hF, 0, 0, 1, 0,  0, 1, 0, 1, 'h0006, 0, 0);
    v[27] = mk('h50, 'hF, 0, 0, 1, 0,  4, 0, 0, 1, 'h0000, 2, 0);
    v[28] = mk('h50, 'hF, 0, 0, 1, 0,  4, 1, 0, 1, 'h0203, 2, 0);
    v[29] = mk('h50, 'hF, 0, 0, 1, 0,  4, 1, 0, 1, 'h0204, 2, 0);
    v[30] = mk('h50, 'hF, 0, 0, 1, 0,  4, 1, 0, 1, 'h0205, 2, 0);
    v[31] = mk('h50, 'hF, 0, 0, 1, 0,  0, 1, 0, 1, 'h0206, 2, 0);
    v[32] = mk('h50, 'hF, 0, 0, 1, 0,  8, 0, 0, 1, 'h0000, 3, 0);
    v[33] = mk('h50, 'hF, 0, 0, 0, 1,  8, 1, 0, 1, 'h0303, 3, 0);
    v[34] = mk('h50, 'hF, 0, 0, 1, 0,  0, 0, 0, 0, 'h0000, 0, 1);
    v[35] = mk('h55, 'hF, 0, 0, 1, 0,  0, 0, 0, 0, 'h0000, 3, 0);
    v[36] = mk('h55, 'hF, 1, 0, 1, 0,  1, 0, 0, 0, 'h0000, 0, 0);
    v[37] = mk('h55, 'hF, 0, 0, 1, 0,  0, 1, 1, 1, 'h0007, 0, 0);
    v[38] = mk('h55, 'hF, 0, 0, 1, 0,  2, 0, 1, 1, 'h0000, 1, 0);
    v[39] = mk('h51, 'hD, 0, 0, 1, 0,  2, 1, 0, 1, 'h0103, 1, 0);
    v[40] = mk('h51, 'hD, 0, 0, 1, 0,  0, 0, 0, 1, 'h0000, 1, 0);
    v[41] = mk('h55, 'hF, 0, 0, 1, 0,  4, 0, 0, 1, 'h0000, 2, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 42; k++) begin
      slv_mode = v[k].mode;
      slv_data_valid = v[k].dv;
      slv_proc_valid = v[k].pv;
      fifo_full = v[k].full;
      fifo_empty = v[k].empty;
      proc_cmplt = v[k].pc;
      #3 check($sformatf("v%0d", k), v[k].e);
      @(posedge clk);
      #1;
    end
    // Mid-burst async reset: slave 2 beat 7 is in the output register here
    #2 rst = 1'b1;
    #1 check("rst_mid", '0);
    @(posedge clk);
    #1 rst = 1'b0;
    #3 check("rst_idle", '0);
    @(posedge clk);
    #4 check("rst_ptr0", '{rdy: 4'h1, v: 1'b0, pv: 1'b0, mode: 2'd0, data: 32'h0, src: 2'd0, mc: 1'b0});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
